shift_issue_stage: RTL and testbench
====================================

# shift_issue_stage

Operand-issue stage placed directly upstream of `barrelshifter32`. It accepts RV32I shift instructions with their register operands and decodes them into the shifter's control inputs (`i`, `s`, `func3`, `is_sra`). Decoded operations are held in a two-entry skid buffer behind a valid/ready handshake, so the combinational shifter always sees a registered, stable operand set. The stage also flags non-shift encodings and counts issued shifts.

## Interface
- `CNT_W`, default 32: width of the issued-shift counter.
- `clk  in  1`: clock; all state updates on the rising edge.
- `rst  in  1`: reset, synchronous, active-high.
- `flush  in  1`: synchronous discard of all buffered entries.
- `in_valid  in  1`: upstream holds a valid instruction.
- `in_ready  out  1`: stage can accept this cycle.
- `in_instr  in  32`: raw instruction word.
- `in_rs1_val  in  32`: rs1 operand; becomes the shifter data input.
- `in_rs2_val  in  32`: rs2 operand; bits [4:0] are the shift amount for OP-class shifts.
- `out_valid  out  1`: output entry valid.
- `out_ready  in  1`: downstream consumes the entry this cycle.
- `out_data  out  32`: drives the shifter's `i` input.
- `out_shamt  out  5`: drives the shifter's `s[4:0]`. Upper bits of `s` are tied to 0 by the integrator.
- `out_func3  out  3`: drives the shifter's `func3`.
- `out_is_sra  out  1`: drives the shifter's `is_sra`.
- `out_rd  out  5`: destination register, `instr[11:7]`.
- `out_illegal  out  1`: entry is not a legal shift.
- `stat_issued  out  CNT_W`: count of legal shifts handed downstream.

## Operation
- **Decode.** Let `op = instr[6:0]`, `f3 = instr[14:12]`, `f7 = instr[31:25]`.
  - `op = 0110011`:
    - `f3 = 001` with `f7 = 0000000` → SLL.
    - `f3 = 101` with `f7 = 0000000` → SRL.
    - `f3 = 101` with `f7 = 0100000` → SRA.
    - For all of these, shamt = `rs2_val[4:0]`.
  - `op = 0010011`: the same `f3`/`f7` rules give SLLI, SRLI and SRAI; shamt = `instr[24:20]`.
  - A legal entry carries `func3 = f3`, `is_sra = (f7 == 0100000)`, `data = rs1_val`, `illegal = 0`.
  - Anything else is forwarded with `illegal = 1`, `shamt = 0`, `func3 = 000`, `is_sra = 0`, `data = rs1_val`. The shifter then passes the data through unchanged, and downstream traps.
- **Buffer.** Two registers: the output register (OR) drives `out_*`; the skid register (SK) holds overflow.
- **States:**
  - EMPTY: OR invalid, SK invalid.
  - ONE: OR valid, SK invalid.
  - TWO: OR valid, SK valid.
- **Signals.**
  - `in_ready = !rst && state != TWO`.
  - `out_valid = (state != EMPTY)`.
  - Accept = `in_valid && in_ready`.
  - Drain = `out_valid && out_ready`.
- **Transitions:**
  - EMPTY, accept → ONE; the decoded input is loaded into OR.
  - ONE, accept and no drain → TWO; the input is loaded into SK.
  - ONE, accept and drain → ONE; OR is reloaded from the input.
  - ONE, drain only → EMPTY.
  - TWO, drain → ONE; SK moves to OR.
  - TWO cannot accept because `in_ready = 0`.
- **Ordering.** Entries leave strictly in acceptance order.
- **Flush** has priority over everything:
  - Next state is EMPTY and both entries are invalidated.
  - An input presented in the same cycle is dropped.
  - A drain in the same cycle still counts as consumed.
- **Counter.** `stat_issued` increments by 1 on every drain with `out_illegal = 0`. It wraps modulo 2^CNT_W and is not cleared by flush.

## Timing
- **Reset values:**
  - state EMPTY, `out_valid = 0`.
  - All `out_*` data fields 0.
  - `stat_issued = 0`.
  - `in_ready = 0` while `rst` is high; 1 in the first cycle after deassertion.
- **Reset mid-operation** discards all entries at the same edge and ignores concurrent in/out handshakes. The counter does not increment on that edge.
- **Latency:** an instruction accepted at edge N is visible on `out_*` after edge N if OR was empty or drained at N; otherwise it becomes visible one cycle after OR drains.
- **Throughput:** one instruction per cycle with `out_ready` held high. Backpressure of one cycle absorbs exactly one extra entry before `in_ready` drops.
- **Stability:** `out_*` is stable while `out_valid && !out_ready` (no flush).
- **`in_ready`** depends only on registered state and `rst`. There is no combinational path from `out_ready`.

## Test plan
- **Reset:** assert `rst` for 2 cycles with `in_valid = 1` → `out_valid = 0`, `in_ready = 0`, `stat_issued = 0`. One cycle after release, `in_ready = 1`.
- **SRAI decode:** `instr = 0x41F0D093` (srai x1,x1,31), `rs1 = 0x80000000`, `out_ready = 1` → the next cycle shows `out_shamt = 31`, `func3 = 101`, `is_sra = 1`, `rd = 1`, `data = 0x80000000`. Then `stat_issued = 1`.
- **SLL decode:** `instr = 0x002091B3` (sll x3,x1,x2), `rs2 = 0xFFFFFFE4` → `out_shamt = 4`, `func3 = 001`, `is_sra = 0`, `illegal = 0`.
- **Illegal encoding:** `instr = 0x00208033` (add) → `out_illegal = 1`, `shamt = 0`, `func3 = 000`. `stat_issued` is unchanged after the drain.
- **Backpressure:** hold `out_ready = 0` and send A, B, C back-to-back → A and B are accepted, and `in_ready` falls after B. Release `out_ready` → outputs appear as A, B, C in order, with C accepted once the state leaves TWO.
- **Flush:** in TWO, assert `flush` together with `in_valid` → `out_valid = 0` and `in_ready = 1` next cycle, and the concurrent input never appears on `out_*`.

Source files
------------

// File: rtl/shift_issue_stage.sv
// rtl/shift_issue_stage.sv - RV32I shift decode and two-entry skid buffer feeding barrelshifter32
module shift_issue_stage #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [31:0]      in_rs1_val,
    input  logic [31:0]      in_rs2_val,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [4:0]       out_shamt,
    output logic [2:0]       out_func3,
    output logic             out_is_sra,
    output logic [4:0]       out_rd,
    output logic             out_illegal,
    output logic [CNT_W-1:0] stat_issued
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  shamt;
        logic [2:0]  func3;
        logic        is_sra;
        logic [4:0]  rd;
        logic        illegal;
    } entry_t;

    localparam logic [6:0] OP_REG = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] F7_0   = 7'b0000000;
    localparam logic [6:0] F7_SRA = 7'b0100000;

    state_t state;
    state_t state_next;
    entry_t or_q;
    entry_t sk_q;
    entry_t dec;

    logic accept;
    logic drain;
    logic load_or_in;
    logic load_or_sk;
    logic load_sk;

    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       is_shift_op;
    logic       legal;

    // Decode
    always_comb begin
        op          = in_instr[6:0];
        f3          = in_instr[14:12];
        f7          = in_instr[31:25];
        is_shift_op = (op == OP_REG) || (op == OP_IMM);
        legal       = is_shift_op &&
                      (((f3 == 3'b001) && (f7 == F7_0)) ||
                       ((f3 == 3'b101) && ((f7 == F7_0) || (f7 == F7_SRA))));
        dec         = '0;
        dec.data    = in_rs1_val;
        dec.rd      = in_instr[11:7];
        dec.illegal = !legal;
        if (legal) begin
            dec.shamt  = (op == OP_REG) ? in_rs2_val[4:0] : in_instr[24:20];
            dec.func3  = f3;
            dec.is_sra = (f7 == F7_SRA);
        end
    end

    assign accept = in_valid && in_ready;
    assign drain  = out_valid && out_ready;

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // FSM: next state
    always_comb begin
        state_next = state;
        case (state)
            EMPTY: begin
                if (accept) begin
                    state_next = ONE;
                end
            end
            ONE: begin
                if (accept && !drain) begin
                    state_next = TWO;
                end else if (!accept && drain) begin
                    state_next = EMPTY;
                end
            end
            TWO: begin
                if (drain) begin
                    state_next = ONE;
                end
            end
            default: state_next = EMPTY;
        endcase
        if (flush) begin
            state_next = EMPTY;
        end
    end

    // FSM: outputs and datapath load enables
    always_comb begin
        in_ready   = !rst && (state != TWO);
        out_valid  = (state != EMPTY);
        load_or_in = 1'b0;
        load_or_sk = 1'b0;
        load_sk    = 1'b0;
        if (!flush) begin
            case (state)
                EMPTY:   load_or_in = accept;
                ONE: begin
                    load_or_in = accept && drain;
                    load_sk    = accept && !drain;
                end
                TWO:     load_or_sk = drain;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            or_q <= '0;
            sk_q <= '0;
        end else begin
            if (load_or_in) begin
                or_q <= dec;
            end else if (load_or_sk) begin
                or_q <= sk_q;
            end
            if (load_sk) begin
                sk_q <= dec;
            end
        end
    end

    // Flush does not cancel a drain that happens in the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_issued <= '0;
        end else if (drain && !or_q.illegal) begin
            stat_issued <= stat_issued + CNT_W'(1);
        end
    end

    assign out_data    = or_q.data;
    assign out_shamt   = or_q.shamt;
    assign out_func3   = or_q.func3;
    assign out_is_sra  = or_q.is_sra;
    assign out_rd      = or_q.rd;
    assign out_illegal = or_q.illegal;

endmodule

// File: tb/tb_shift_issue_stage.sv
// tb/tb_shift_issue_stage.sv - directed self-checking bench for shift_issue_stage
module tb_shift_issue_stage;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_rs1_val;
    logic [31:0] in_rs2_val;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_shamt;
    logic [2:0]  out_func3;
    logic        out_is_sra;
    logic [4:0]  out_rd;
    logic        out_illegal;
    logic [31:0] stat_issued;

    int n_checks = 0;
    int n_pass   = 0;

    shift_issue_stage #(.CNT_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_rs1_val  (in_rs1_val),
        .in_rs2_val  (in_rs2_val),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_shamt   (out_shamt),
        .out_func3   (out_func3),
        .out_is_sra  (out_is_sra),
        .out_rd      (out_rd),
        .out_illegal (out_illegal),
        .stat_issued (stat_issued)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] rs1,
                         input logic [31:0] rs2);
        in_valid   = v;
        in_instr   = instr;
        in_rs1_val = rs1;
        in_rs2_val = rs2;
    endtask

    task automatic check_entry(input string tag, input logic [31:0] data, input logic [4:0] shamt,
                               input logic [2:0] f3, input logic sra, input logic [4:0] rd,
                               input logic ill);
        check({tag, ".valid"},   32'(out_valid),   32'd1);
        check({tag, ".data"},    out_data,         data);
        check({tag, ".shamt"},   32'(out_shamt),   32'(shamt));
        check({tag, ".func3"},   32'(out_func3),   32'(f3));
        check({tag, ".is_sra"},  32'(out_is_sra),  32'(sra));
        check({tag, ".rd"},      32'(out_rd),      32'(rd));
        check({tag, ".illegal"}, 32'(out_illegal), 32'(ill));
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(1'b1, 32'h41F0D093, 32'h11111111, 32'h0);

        // Reset held two cycles with a valid input present
        step();
        step();
        check("rst.out_valid", 32'(out_valid), 32'd0);
        check("rst.in_ready",  32'(in_ready),  32'd0);
        check("rst.stat",      stat_issued,    32'd0);
        check("rst.out_data",  out_data,       32'd0);
        rst = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 32'h0);
        step();
        check("rst.release_in_ready", 32'(in_ready), 32'd1);
        check("rst.release_valid",    32'(out_valid), 32'd0);

        // srai x1,x1,31
        out_ready = 1'b1;
        drive(1'b1, 32'h41F0D093, 32'h80000000, 32'h0);
        step();
        check_entry("srai", 32'h80000000, 5'd31, 3'b101, 1'b1, 5'd1, 1'b0);
        check("srai.stat_before", stat_issued, 32'd0);
        drive(1'b0, 32'h0, 32'h0, 32'h0);
        step();
        check("srai.stat_after", stat_issued, 32'd1);
        check("srai.drained",    32'(out_valid), 32'd0);

        // sll x3,x1,x2 : shamt from rs2[4:0]
        drive(1'b1, 32'h002091B3, 32'h12345678, 32'hFFFFFFE4);
        step();
        check_entry("sll", 32'h12345678, 5'd4, 3'b001, 1'b0, 5'd3, 1'b0);
        // srli x1,x1,4 back-to-back at full throughput
        drive(1'b1, 32'h0040D093, 32'h0000F000, 32'hFFFFFFFF);
        step();
        check_entry("srli", 32'h0000F000, 5'd4, 3'b101, 1'b0, 5'd1, 1'b0);
        check("srli.stat", stat_issued, 32'd2);

        // add is not a shift
        drive(1'b1, 32'h00208033, 32'hCAFEF00D, 32'h00000003);
        step();
        check_entry("add", 32'hCAFEF00D, 5'd0, 3'b000, 1'b0, 5'd0, 1'b1);
        check("add.stat_before", stat_issued, 32'd3);
        // slli with f7=0100000 is illegal too
        drive(1'b1, 32'h40409093, 32'h0000BEEF, 32'h0);
        step();
        check_entry("slli_f7", 32'h0000BEEF, 5'd0, 3'b000, 1'b0, 5'd1, 1'b1);
        drive(1'b0, 32'h0, 32'h0, 32'h0);
        step();
        check("illegal.stat_unchanged", stat_issued, 32'd3);

        // Backpressure: A, B accepted, C stalls until TWO drains
        out_ready = 1'b0;
        drive(1'b1, 32'h0040D093, 32'hAAAA0001, 32'h0);
        step();
        check("bp.A_in_ready", 32'(in_ready), 32'd1);
        drive(1'b1, 32'h002091B3, 32'hBBBB0002, 32'h00000007);
        step();
        check("bp.B_in_ready", 32'(in_ready), 32'd0);
        check("bp.B_out_data", out_data, 32'hAAAA0001);
        drive(1'b1, 32'h41F0D093, 32'hCCCC0003, 32'h0);
        step();
        check("bp.stall_in_ready", 32'(in_ready), 32'd0);
        check_entry("bp.A_stable", 32'hAAAA0001, 5'd4, 3'b101, 1'b0, 5'd1, 1'b0);
        out_ready = 1'b1;
        step();
        check_entry("bp.B", 32'hBBBB0002, 5'd7, 3'b001, 1'b0, 5'd3, 1'b0);
        check("bp.B_in_ready", 32'(in_ready), 32'd1);
        step();
        check_entry("bp.C", 32'hCCCC0003, 5'd31, 3'b101, 1'b1, 5'd1, 1'b0);
        drive(1'b0, 32'h0, 32'h0, 32'h0);
        step();
        check("bp.empty", 32'(out_valid), 32'd0);
        check("bp.stat",  stat_issued,    32'd6);

        // Flush in TWO with concurrent input and drain
        out_ready = 1'b0;
        drive(1'b1, 32'h002091B3, 32'hD0D0D0D0, 32'h00000001);
        step();
        drive(1'b1, 32'h002091B3, 32'hE0E0E0E0, 32'h00000002);
        step();
        check("fl.in_two", 32'(in_ready), 32'd0);
        flush = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, 32'h0040D093, 32'hF0F0F0F0, 32'h0);
        step();
        check("fl.out_valid", 32'(out_valid), 32'd0);
        check("fl.in_ready",  32'(in_ready),  32'd1);
        check("fl.stat",      stat_issued,    32'd7);
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 32'h0);
        step();
        check("fl.no_ghost", 32'(out_valid), 32'd0);

        // Reset mid-operation with concurrent handshakes
        out_ready = 1'b0;
        drive(1'b1, 32'h41F0D093, 32'h12121212, 32'h0);
        step();
        rst = 1'b1;
        out_ready = 1'b1;
        step();
        check("mrst.out_valid", 32'(out_valid), 32'd0);
        check("mrst.stat",      stat_issued,    32'd0);
        check("mrst.out_data",  out_data,       32'd0);
        rst = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 32'h0);
        step();
        check("mrst.in_ready", 32'(in_ready), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
